ad_ip_jesd204_tpl_adc_deframer: RTL and testbench

Receive-side transport-layer core for the JESD204 TPL. It takes lane-ordered link beats from the JESD204 link layer and deframes them into per-channel 16-bit sample words. It applies data-format conversion and drives the ADC DMA/packer interface. Each channel also has a self-synchronising PN9 monitor whose status feeds the ADC regmap.

---
 rtl/ad_ip_jesd204_tpl_adc_deframer.sv | 176 +++++++++++++++++
 tb/tb_ad_ip_jesd204_tpl_adc_deframer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad_ip_jesd204_tpl_adc_deframer.sv
// JESD204 receive transport layer: deframes lane beats into per-channel 16-bit
// samples, applies data-format conversion and runs a PN9 monitor per channel.
module ad_ip_jesd204_tpl_adc_deframer #(
  parameter int NUM_LANES            = 4,
  parameter int NUM_CHANNELS         = 2,
  parameter int SAMPLES_PER_FRAME    = 1,
  parameter int CONVERTER_RESOLUTION = 16,
  parameter int BITS_PER_SAMPLE      = 16,
  parameter int OCTETS_PER_BEAT      = 4,
  parameter int PN_LOCK_COUNT        = 16,
  parameter int PN_LOSS_COUNT        = 4,
  localparam int F   = NUM_CHANNELS * SAMPLES_PER_FRAME * BITS_PER_SAMPLE / (8 * NUM_LANES),
  localparam int FPB = OCTETS_PER_BEAT / F,
  localparam int DPW = FPB * SAMPLES_PER_FRAME
) (
  input  logic                                   clk,
  input  logic                                   resetn,
  input  logic                                   link_valid,
  input  logic [NUM_LANES*8*OCTETS_PER_BEAT-1:0] link_data,
  input  logic [NUM_CHANNELS-1:0]                enable,
  input  logic                                   adc_dfmt_type,
  input  logic                                   adc_dfmt_se,
  output logic [NUM_CHANNELS-1:0]                adc_valid,
  output logic [NUM_CHANNELS*16*DPW-1:0]         adc_data,
  input  logic [NUM_CHANNELS-1:0]                pn_err_clr,
  output logic [NUM_CHANNELS-1:0]                pn_oos,
  output logic [NUM_CHANNELS-1:0]                pn_err
);

  localparam int NP    = BITS_PER_SAMPLE;
  localparam int N     = CONVERTER_RESOLUTION;
  localparam int S     = SAMPLES_PER_FRAME;
  localparam int LW    = 8 * OCTETS_PER_BEAT;
  localparam int FW    = 8 * F * NUM_LANES;
  localparam int BW    = 16 * DPW;
  localparam int CNT_W = $clog2((PN_LOCK_COUNT > PN_LOSS_COUNT ? PN_LOCK_COUNT : PN_LOSS_COUNT) + 1);
  localparam logic [15:0] EXT_MASK = 16'(~((32'd1 << N) - 32'd1));

  typedef enum logic {PN_OOS, PN_SYNC} pn_state_t;

  function automatic logic [15:0] format_sample(input logic [NP-1:0] smp,
                                                input logic dtype, input logic se);
    logic [N-1:0] raw;
    logic [15:0]  r;
    raw = smp[NP-1 -: N];
    if (dtype) raw[N-1] = ~raw[N-1];
    r = 16'(raw);
    if (se && raw[N-1]) r = r | EXT_MASK;
    return r;
  endfunction

  // Continues the PN9 stream (b[n] = b[n-5] ^ b[n-9]) from the last 9 bits seen;
  // seed[0] is the most recent bit, output sample t at [t*16 +: 16], MSB first.
  function automatic logic [BW-1:0] pn9_beat(input logic [8:0] seed);
    logic [8:0]    h;
    logic          nb;
    logic [BW-1:0] r;
    // NOTE: blocking assignments are right here: h is a temporary that must update within one evaluation.
    h = seed;
    r = '0;
    for (int t = 0; t < DPW; t++) begin
      for (int i = 15; i >= 0; i--) begin
        nb          = h[4] ^ h[8];
        r[t*16 + i] = nb;
        h           = {h[7:0], nb};
      end
    end
    return r;
  endfunction

  logic [NUM_CHANNELS*DPW*NP-1:0] df_flat;
  logic [NUM_CHANNELS*DPW*NP-1:0] s1_data;
  logic [NUM_CHANNELS*BW-1:0]     fmt_flat;
  logic [NUM_CHANNELS*BW-1:0]     s2_data;
  logic                           s1_valid;
  logic                           s2_valid;

  for (genvar k = 0; k < FPB; k++) begin : g_frame
    logic [FW-1:0] frame;
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      for (genvar j = 0; j < F; j++) begin : g_oct
        assign frame[FW-1-(i*F+j)*8 -: 8] = link_data[i*LW + (k*F+j)*8 +: 8];
      end
    end
    for (genvar m = 0; m < NUM_CHANNELS; m++) begin : g_conv
      for (genvar s = 0; s < S; s++) begin : g_smp
        assign df_flat[(m*DPW + k*S + s)*NP +: NP] = frame[FW-1-(m*S+s)*NP -: NP];
      end
    end
  end

  for (genvar n = 0; n < NUM_CHANNELS * DPW; n++) begin : g_fmt
    assign fmt_flat[n*16 +: 16] = format_sample(s1_data[n*NP +: NP], adc_dfmt_type, adc_dfmt_se);
  end

  // NOTE: sample registers are reset too, so adc_data reads zero straight out of reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_data  <= '0;
      s2_data  <= '0;
    end else begin
      s1_valid <= link_valid;
      s1_data  <= df_flat;
      s2_valid <= s1_valid;
      s2_data  <= fmt_flat;
    end
  end

  for (genvar m = 0; m < NUM_CHANNELS; m++) begin : g_pn
    logic [BW-1:0]    beat;
    logic [BW-1:0]    expected;
    logic [8:0]       seed;
    logic             seeded;
    logic             match;
    pn_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic             oos;
    logic             err;

    assign adc_valid[m]           = s2_valid & enable[m];
    assign adc_data[m*BW +: BW]   = enable[m] ? s2_data[m*BW +: BW] : '0;
    assign beat                   = s2_data[m*BW +: BW];
    assign expected               = pn9_beat(seed);
    assign match                  = (beat == expected) && (beat != '0);
    assign pn_oos[m]              = oos;
    assign pn_err[m]              = err;

    always_ff @(posedge clk) begin
      if (!resetn) begin
        state  <= PN_OOS;
        cnt    <= '0;
        oos    <= 1'b1;
        err    <= 1'b0;
        seeded <= 1'b0;
        seed   <= '0;
      end else begin
        // A fresh mismatch outranks a simultaneous clear.
        err <= (err & ~pn_err_clr[m]) | (s2_valid & seeded & (state == PN_SYNC) & ~match);
        if (s2_valid) begin
          seeded <= 1'b1;
          seed   <= beat[(DPW-1)*16 +: 9];
          if (seeded) begin
            case (state)
              PN_OOS: begin
                if (!match) begin
                  cnt <= '0;
                end else if (cnt == CNT_W'(PN_LOCK_COUNT - 1)) begin
                  state <= PN_SYNC;
                  oos   <= 1'b0;
                  cnt   <= '0;
                end else begin
                  cnt <= cnt + 1'b1;
                end
              end
              PN_SYNC: begin
                if (match) begin
                  cnt <= '0;
                end else if (cnt == CNT_W'(PN_LOSS_COUNT - 1)) begin
                  state <= PN_OOS;
                  oos   <= 1'b1;
                  cnt   <= '0;
                end else begin
                  cnt <= cnt + 1'b1;
                end
              end
              default: state <= PN_OOS;
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_deframer.sv
// Bench for the JESD204 TPL ADC deframer: directed vectors, a format table and
// randomized PN streams checked against a cycle-level reference model.
module tb_ad_ip_jesd204_tpl_adc_deframer;

  localparam int L   = 4;
  localparam int M   = 2;
  localparam int OPB = 4;
  localparam int DPW = 4;
  localparam int DW  = M * 16 * DPW;

  logic            clk = 1'b0;
  logic            resetn;
  logic            link_valid;
  logic [L*8*OPB-1:0] link_data;
  logic [M-1:0]    enable;
  logic            adc_dfmt_type;
  logic            adc_dfmt_se;
  logic [M-1:0]    pn_err_clr;
  logic [M-1:0]    adc_valid, pn_oos, pn_err;
  logic [DW-1:0]   adc_data;
  logic [M-1:0]    adc_valid14, pn_oos14, pn_err14;
  logic [DW-1:0]   adc_data14;

  always #5 clk = ~clk;

  ad_ip_jesd204_tpl_adc_deframer dut (
    .clk(clk), .resetn(resetn), .link_valid(link_valid), .link_data(link_data),
    .enable(enable), .adc_dfmt_type(adc_dfmt_type), .adc_dfmt_se(adc_dfmt_se),
    .adc_valid(adc_valid), .adc_data(adc_data), .pn_err_clr(pn_err_clr),
    .pn_oos(pn_oos), .pn_err(pn_err)
  );

  ad_ip_jesd204_tpl_adc_deframer #(.CONVERTER_RESOLUTION(14)) dut14 (
    .clk(clk), .resetn(resetn), .link_valid(link_valid), .link_data(link_data),
    .enable(enable), .adc_dfmt_type(adc_dfmt_type), .adc_dfmt_se(adc_dfmt_se),
    .adc_valid(adc_valid14), .adc_data(adc_data14), .pn_err_clr(pn_err_clr),
    .pn_oos(pn_oos14), .pn_err(pn_err14)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m1_v, m2_v;
  logic [127:0] m1_raw;
  logic [15:0] m2_smp [M][DPW];
  bit          ms_seeded [M];
  bit          ms_hist   [M][9];
  bit          ms_oos    [M];
  bit          ms_err    [M];
  int          ms_cnt    [M];

  function automatic logic [15:0] deframe_model(input logic [127:0] d, input int ch, input int t);
    // One octet per lane per frame: frame t is octet t of lanes 0..3, converter ch owns lanes 2ch, 2ch+1.
    logic [7:0] hi, lo;
    hi = d[(2*ch)*32 + t*8 +: 8];
    lo = d[(2*ch+1)*32 + t*8 +: 8];
    return {hi, lo};
  endfunction

  function automatic logic [15:0] fmt_model(input logic [15:0] s, input int n, input bit dt, input bit se);
    int v;
    v = int'(s) >> (16 - n);
    if (dt) v = v ^ (1 << (n - 1));
    if (se && v >= (1 << (n - 1))) v = v - (1 << n);
    return 16'(v);
  endfunction

  task automatic pn_model(input int c);
    bit w [9 + 16*DPW];
    bit good, nonzero, new_err;
    new_err = 1'b0;
    if (m2_v) begin
      if (ms_seeded[c]) begin
        for (int i = 0; i < 9; i++) w[i] = ms_hist[c][i];
        for (int n = 9; n < 9 + 16*DPW; n++) w[n] = w[n-5] ^ w[n-9];
        good = 1'b1;
        nonzero = 1'b0;
        for (int t = 0; t < DPW; t++) begin
          if (m2_smp[c][t] != 16'h0) nonzero = 1'b1;
          for (int i = 0; i < 16; i++)
            if (m2_smp[c][t][15-i] != w[9 + 16*t + i]) good = 1'b0;
        end
        good = good && nonzero;
        if (ms_oos[c]) begin
          ms_cnt[c] = good ? ms_cnt[c] + 1 : 0;
          if (ms_cnt[c] == 16) begin ms_oos[c] = 1'b0; ms_cnt[c] = 0; end
        end else begin
          new_err   = !good;
          ms_cnt[c] = good ? 0 : ms_cnt[c] + 1;
          if (ms_cnt[c] == 4) begin ms_oos[c] = 1'b1; ms_cnt[c] = 0; end
        end
      end
      ms_seeded[c] = 1'b1;
      for (int i = 0; i < 9; i++) ms_hist[c][i] = m2_smp[c][DPW-1][8-i];
    end
    ms_err[c] = (ms_err[c] && !pn_err_clr[c]) || new_err;
  endtask

  task automatic model_edge();
    if (!resetn) begin
      m1_v = 1'b0; m2_v = 1'b0; m1_raw = '0;
      for (int c = 0; c < M; c++) begin
        for (int t = 0; t < DPW; t++) m2_smp[c][t] = 16'h0;
        ms_seeded[c] = 1'b0; ms_oos[c] = 1'b1; ms_err[c] = 1'b0; ms_cnt[c] = 0;
        for (int i = 0; i < 9; i++) ms_hist[c][i] = 1'b0;
      end
    end else begin
      for (int c = 0; c < M; c++) pn_model(c);
      m2_v = m1_v;
      for (int c = 0; c < M; c++)
        for (int t = 0; t < DPW; t++)
          m2_smp[c][t] = fmt_model(deframe_model(m1_raw, c, t), 16, adc_dfmt_type, adc_dfmt_se);
      m1_v   = link_valid;
      m1_raw = link_data;
    end
  endtask

  task automatic tick();
    logic [DW-1:0] ed;
    logic [M-1:0]  ev, eo, ee;
    @(posedge clk);
    model_edge();
    #1;
    ed = '0;
    for (int c = 0; c < M; c++) begin
      ev[c] = m2_v && enable[c];
      eo[c] = ms_oos[c];
      ee[c] = ms_err[c];
      if (enable[c])
        for (int t = 0; t < DPW; t++) ed[c*64 + t*16 +: 16] = m2_smp[c][t];
    end
    check("adc_valid", adc_valid, ev);
    check("adc_data", adc_data, ed);
    check("pn_oos", pn_oos, eo);
    check("pn_err", pn_err, ee);
  endtask

  // ---------------- PN9 stimulus ----------------
  bit pn_seq [511];
  int gpos   [M];

  function automatic logic [15:0] pn_word(input int pos);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[15-i] = pn_seq[(pos + i) % 511];
    return r;
  endfunction

  task automatic drive_pn(input logic [M-1:0] corrupt);
    logic [127:0] d;
    logic [15:0]  w;
    d = '0;
    for (int c = 0; c < M; c++) begin
      for (int t = 0; t < DPW; t++) begin
        w = pn_word(gpos[c] + 16*t);
        if (corrupt[c] && t == 0) w = w ^ 16'h0100;
        d[(2*c)*32 + t*8 +: 8]   = w[15:8];
        d[(2*c+1)*32 + t*8 +: 8] = w[7:0];
      end
      gpos[c] = (gpos[c] + 64) % 511;
    end
    link_data  = d;
    link_valid = 1'b1;
  endtask

  typedef struct {
    bit          dtype;
    bit          se;
    logic [15:0] exp16;
    logic [15:0] exp14;
  } fmt_vec_t;

  fmt_vec_t fmt_tab [4];

  initial begin
    logic [M-1:0] cor;

    for (int n = 0; n < 9; n++) pn_seq[n] = 1'b1;
    for (int n = 9; n < 511; n++) pn_seq[n] = pn_seq[n-5] ^ pn_seq[n-9];
    gpos[0] = 0;
    gpos[1] = 200;

    // Sample 0x8004: N=16 keeps all bits, N=14 keeps raw 0x2001.
    fmt_tab[0] = '{1'b0, 1'b1, 16'h8004, 16'hE001};
    fmt_tab[1] = '{1'b1, 1'b1, 16'h0004, 16'h0001};
    fmt_tab[2] = '{1'b0, 1'b0, 16'h8004, 16'h2001};
    fmt_tab[3] = '{1'b1, 1'b0, 16'h0004, 16'h0001};

    resetn = 1'b0; link_valid = 1'b0; link_data = '0; enable = 2'b11;
    adc_dfmt_type = 1'b0; adc_dfmt_se = 1'b1; pn_err_clr = '0;
    tick(); tick();
    check("rst_valid", adc_valid, 2'b00);
    check("rst_data", adc_data, '0);
    check("rst_oos", pn_oos, 2'b11);
    check("rst_err", pn_err, 2'b00);
    resetn = 1'b1;
    tick();

    // Deframe of a single hand-built beat.
    link_data  = {32'h00FFEEDD, 32'hCCBBAA99, 32'h88776655, 32'h44332211};
    link_valid = 1'b1;
    tick();
    link_valid = 1'b0;
    tick();
    check("deframe_valid", adc_valid, 2'b11);
    check("deframe_ch0", adc_data[63:0], {16'h4488, 16'h3377, 16'h2266, 16'h1155});
    check("deframe_ch1", adc_data[127:64], {16'hCC00, 16'hBBFF, 16'hAAEE, 16'h99DD});
    tick();
    check("deframe_pulse", adc_valid, 2'b00);

    // Format table on the N=16 and N=14 instances.
    for (int v = 0; v < 4; v++) begin
      adc_dfmt_type = fmt_tab[v].dtype;
      adc_dfmt_se   = fmt_tab[v].se;
      link_data     = '0;
      link_data[7:0]   = 8'h80;
      link_data[39:32] = 8'h04;
      link_valid    = 1'b1;
      tick();
      link_valid = 1'b0;
      tick();
      check("fmt_n16", adc_data[15:0], fmt_tab[v].exp16);
      check("fmt_n14", adc_data14[15:0], fmt_tab[v].exp14);
      check("fmt_n14_valid", adc_valid14, 2'b11);
      tick();
    end
    adc_dfmt_type = 1'b0;
    adc_dfmt_se   = 1'b1;

    // PN lock/loss with channel 1 disabled.
    resetn = 1'b0; tick(); resetn = 1'b1;
    enable = 2'b01;
    for (int j = 1; j <= 40; j++) begin
      cor = '0;
      if (j == 25 || (j >= 31 && j <= 34)) cor = 2'b01;
      pn_err_clr = (j == 27 || j == 28) ? 2'b01 : 2'b00;
      drive_pn(cor);
      tick();
      if (j == 18) check("lock_before", pn_oos, 2'b11);
      if (j == 19) check("lock_after_17", pn_oos, 2'b00);
      if (j == 20) begin
        check("en_valid", adc_valid, 2'b01);
        check("en_ch1_zero", adc_data[127:64], '0);
      end
      if (j == 27) begin
        check("err_set_wins", pn_err, 2'b01);
        check("err_stays_sync", pn_oos, 2'b00);
      end
      if (j == 28) check("err_cleared", pn_err, 2'b00);
      if (j == 35) check("loss_before", pn_oos, 2'b00);
      if (j == 36) check("loss_after_4", pn_oos, 2'b01);
    end
    pn_err_clr = '0;

    // One-cycle reset in the middle of a stream.
    enable = 2'b11;
    resetn = 1'b0;
    drive_pn('0);
    tick();
    check("midrst_valid0", adc_valid, 2'b00);
    check("midrst_oos", pn_oos, 2'b11);
    check("midrst_err", pn_err, 2'b00);
    resetn = 1'b1;
    drive_pn('0);
    tick();
    check("midrst_valid1", adc_valid, 2'b00);
    drive_pn('0);
    tick();
    check("midrst_resume", adc_valid, 2'b11);

    // All-zero link data never locks.
    link_data  = '0;
    link_valid = 1'b1;
    for (int j = 0; j < 40; j++) tick();
    check("zero_oos", pn_oos, 2'b11);

    // Randomized traffic against the model.
    for (int j = 0; j < 2000; j++) begin
      resetn = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 49) == 0) enable = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) adc_dfmt_type = ~adc_dfmt_type;
      if ($urandom_range(0, 19) == 0) adc_dfmt_se = ~adc_dfmt_se;
      pn_err_clr = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      if ($urandom_range(0, 9) < 8) begin
        cor[0] = ($urandom_range(0, 32) == 0);
        cor[1] = ($urandom_range(0, 32) == 0);
        drive_pn(cor);
      end else begin
        link_valid = 1'b0;
        link_data  = {$urandom, $urandom, $urandom, $urandom};
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
